ibex_irq_arbiter: RTL



---
 rtl/ibex_irq_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_irq_arbiter.sv
// ---------------------------------------------------------------------------
// ibex_irq_arbiter
//
// Sits between the CSR interrupt-pending bits and the controller. Latches the
// NMI on its rising edge, masks maskable sources with the global enable and
// debug mode, picks one winner by priority, and presents it as a registered
// request that stays up until it is acked, withdrawn or times out. Also
// produces a registered "anything pending" flag for WFI wake-up.
//
// Parameters:
//   ACK_TIMEOUT       cycles a request may wait for ack before re-arbitration
//                     (0 = never time out)
//
// Build option:
//   IBEX_IRQ_ARB_FAST_RR_EN  when defined, the 15 fast interrupts are
//                            arbitrated round-robin instead of fixed order
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   irq_nm_i           non-maskable interrupt (edge latched)
//   csr_meip_i         external interrupt pending
//   csr_msip_i         software interrupt pending
//   csr_mtip_i         timer interrupt pending
//   csr_mfip_i[14:0]   fast interrupt pending
//   csr_mstatus_mie_i  global machine interrupt enable
//   priv_mode_i[1:0]   current privilege level (2'b11 = M)
//   debug_mode_i       debug mode, masks everything including NMI
//   irq_ack_i          controller accepted the presented request
//   irq_req_o          interrupt request to the controller
//   irq_cause_o[5:0]   exception cause of the presented request
//   irq_nmi_o          presented request is the NMI
//   irq_pending_o      any raw source pending (unmasked), one cycle late
// ---------------------------------------------------------------------------
module ibex_irq_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        irq_nm_i,
    input  logic        csr_meip_i,
    input  logic        csr_msip_i,
    input  logic        csr_mtip_i,
    input  logic [14:0] csr_mfip_i,
    input  logic        csr_mstatus_mie_i,
    input  logic [1:0]  priv_mode_i,
    input  logic        debug_mode_i,
    input  logic        irq_ack_i,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic        irq_nmi_o,
    output logic        irq_pending_o
);

    // A zero timeout still needs a (dummy) one-bit counter.
    localparam int unsigned CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       cause_q, cause_d;
    logic             nmi_flag_q, nmi_flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nmi_latch_q, nmi_latch_d;
    logic             nm_prev_q;
    logic             pending_q;

    logic             irq_en;
    logic             nmi_elig;
    logic             nmi_ack;
    logic [15:0]      fast_pad;
    logic             fast_found;
    logic [3:0]       fast_idx;
    logic             win_valid;
    logic [5:0]       win_cause;
    logic             win_nmi;
    logic             win_level;
    logic             timeout_hit;
    logic             withdraw;

    assign irq_en   = !debug_mode_i && (csr_mstatus_mie_i || (priv_mode_i != 2'b11));
    assign nmi_elig = nmi_latch_q && !debug_mode_i;
    assign fast_pad = {1'b0, csr_mfip_i};

    // The latch only clears when the NMI request itself is acked; a fresh
    // edge in that same cycle keeps it set.
    assign nmi_ack     = (state_q == REQ) && irq_ack_i && nmi_flag_q;
    assign nmi_latch_d = (irq_nm_i && !nm_prev_q) || (nmi_latch_q && !nmi_ack);

`ifdef IBEX_IRQ_ARB_FAST_RR_EN
    logic [3:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] rr_idx [15];

    // rr_idx[k] is the fast index at priority rank k: the pointer first,
    // then walking downward with wrap from 0 to 14.
    for (genvar gi = 0; gi < 15; gi++) begin : g_rr_order
        assign rr_idx[gi] = (rr_ptr_q >= 4'(gi)) ? (rr_ptr_q - 4'(gi))
                                                 : (rr_ptr_q + 4'(15 - gi));
    end

    // Scan from the lowest rank upward so the highest-ranked hit wins.
    always_comb begin
        fast_found = 1'b0;
        fast_idx   = 4'd0;
        for (int k = 14; k >= 0; k--) begin
            if (fast_pad[rr_idx[k]]) begin
                fast_found = 1'b1;
                fast_idx   = rr_idx[k];
            end
        end
    end
`else
    // Fixed order: the highest set index wins.
    always_comb begin
        fast_found = 1'b0;
        fast_idx   = 4'd0;
        for (int k = 0; k < 15; k++) begin
            if (csr_mfip_i[k]) begin
                fast_found = 1'b1;
                fast_idx   = 4'(k);
            end
        end
    end
`endif

    always_comb begin
        win_valid = 1'b1;
        win_nmi   = 1'b0;
        win_cause = 6'h00;
        if (nmi_elig) begin
            win_nmi   = 1'b1;
            win_cause = 6'h3F;
        end else if (irq_en && fast_found) begin
            // {1'b1, 5'd16 + i} folds to {2'b11, i} for i in 0..14.
            win_cause = {2'b11, fast_idx};
        end else if (irq_en && csr_meip_i) begin
            win_cause = 6'h2B;
        end else if (irq_en && csr_msip_i) begin
            win_cause = 6'h23;
        end else if (irq_en && csr_mtip_i) begin
            win_cause = 6'h27;
        end else begin
            win_valid = 1'b0;
        end
    end

    // Current level of the source behind the presented request. The NMI is
    // edge-latched, so it never "deasserts" while presented.
    always_comb begin
        win_level = 1'b1;
        if (!nmi_flag_q) begin
            if (cause_q[4]) begin
                win_level = fast_pad[cause_q[3:0]];
            end else begin
                case (cause_q[4:0])
                    5'd11:   win_level = csr_meip_i;
                    5'd3:    win_level = csr_msip_i;
                    5'd7:    win_level = csr_mtip_i;
                    default: win_level = 1'b0;
                endcase
            end
        end
    end

    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign withdraw    = !win_level
                      || (!irq_en && !nmi_flag_q)
                      || debug_mode_i
                      || (nmi_latch_q && !nmi_flag_q)
                      || timeout_hit;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        nmi_flag_d = nmi_flag_q;
        cnt_d      = cnt_q;
`ifdef IBEX_IRQ_ARB_FAST_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d    = REQ;
                    cause_d    = win_cause;
                    nmi_flag_d = win_nmi;
                    cnt_d      = '0;
                end
            end
            REQ: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // Ack beats every withdraw reason in the same cycle.
                if (irq_ack_i) begin
                    state_d = ACKD;
`ifdef IBEX_IRQ_ARB_FAST_RR_EN
                    if (!nmi_flag_q && cause_q[4]) begin
                        rr_ptr_d = (cause_q[3:0] == 4'd0) ? 4'd14 : cause_q[3:0] - 4'd1;
                    end
`endif
                end else if (withdraw) begin
                    state_d = IDLE;
                end
            end
            ACKD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cause_q     <= 6'h00;
            nmi_flag_q  <= 1'b0;
            cnt_q       <= '0;
            nmi_latch_q <= 1'b0;
            nm_prev_q   <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            nmi_flag_q  <= nmi_flag_d;
            cnt_q       <= cnt_d;
            nmi_latch_q <= nmi_latch_d;
            nm_prev_q   <= irq_nm_i;
            pending_q   <= nmi_latch_q || csr_meip_i || csr_msip_i || csr_mtip_i
                        || (|csr_mfip_i);
        end
    end

`ifdef IBEX_IRQ_ARB_FAST_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= 4'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign irq_req_o     = (state_q == REQ);
    assign irq_cause_o   = cause_q;
    assign irq_nmi_o     = nmi_flag_q;
    assign irq_pending_o = pending_q;

endmodule
